// File: rtl/frame_gen_scheduler.sv
// Frame generator scheduler for the 64-bit XGMII frame generator.
// Issues one start pulse per frame and holds the configured inter-frame gap.
// Counts completed frames by spotting the terminate character on the TX stream.
// Raises the generator stop interrupt on abort or when a frame overruns the watchdog.
module frame_gen_scheduler #(
  parameter int          DATA_WIDTH       = 64,
  parameter int          CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int          MAX_FRAME_CYCLES = 2048,
  parameter logic [7:0]  INT_STOP         = 8'h02
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [15:0]           i_num_frames,
  input  logic [7:0]            i_ifg_cycles,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
  output logic                  o_start,
  output logic [7:0]            o_interrupt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [15:0]           o_frame_count
);

  localparam int WD_W = $clog2(MAX_FRAME_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_FRAME_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_END,
    S_GAP,
    S_DONE,
    S_ABORT
  } state_t;

  // A lane carries terminate when its control bit is set and its byte is 8'hFD.
  function automatic logic term_detect(input logic [DATA_WIDTH-1:0] data,
                                       input logic [CTRL_WIDTH-1:0] ctrl);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      if (ctrl[k] && (data[8*k +: 8] == 8'hFD)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Frame count holds at all-ones instead of wrapping in continuous mode.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state_q, state_d;
  logic [15:0]     num_q, num_d;
  logic [7:0]      ifg_q, ifg_d;
  logic [7:0]      gap_q, gap_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0]     count_q, count_d;
  logic            timeout_q, timeout_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [7:0]      int_q, int_d;
  logic            term;

  assign term = term_detect(i_tx_data, i_tx_ctrl);

  // Next-state and registered-output decode; outputs follow the state being entered.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    ifg_d     = ifg_q;
    gap_d     = gap_q;
    wd_d      = wd_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          num_d     = i_num_frames;
          ifg_d     = i_ifg_cycles;
          count_d   = 16'd0;
          timeout_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = i_abort ? S_ABORT : S_WAIT_END;
      end
      S_WAIT_END: begin
        wd_d = wd_q + 1'b1;
        if (term) begin
          // A terminate always counts, even when abort or expiry lands on the same cycle.
          count_d = sat_inc16(count_q);
          if (i_abort) begin
            state_d = S_ABORT;
          end else if (((num_q != 16'd0) && (count_d == num_q)) || !i_enable) begin
            state_d = S_DONE;
          end else if (ifg_q == 8'd0) begin
            state_d = S_START;
          end else begin
            gap_d   = ifg_q - 8'd1;
            state_d = S_GAP;
          end
        end else if (i_abort) begin
          state_d = S_ABORT;
        end else if (wd_d == WD_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_ABORT;
        end
      end
      S_GAP: begin
        if (i_abort) begin
          state_d = S_ABORT;
        end else if (!i_enable) begin
          state_d = S_DONE;
        end else if (gap_q == 8'd0) begin
          state_d = S_START;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    int_d   = (state_d == S_ABORT) ? INT_STOP : 8'h00;
  end

  // State, counters and output registers; reset drops everything silently to IDLE.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      num_q     <= 16'd0;
      ifg_q     <= 8'd0;
      gap_q     <= 8'd0;
      wd_q      <= '0;
      count_q   <= 16'd0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      int_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      ifg_q     <= ifg_d;
      gap_q     <= gap_d;
      wd_q      <= wd_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      int_q     <= int_d;
    end
  end

  assign o_start       = start_q;
  assign o_interrupt   = int_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_frame_count = count_q;

endmodule

// File: tb/tb_frame_gen_scheduler.sv
// Directed bench for frame_gen_scheduler: one task per scenario, inline checks.
module tb_frame_gen_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] num;
  logic [7:0]  ifg;
  logic        abort;
  logic [63:0] tx_data;
  logic [7:0]  tx_ctrl;
  logic        o_start;
  logic [7:0]  o_interrupt;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;
  logic [15:0] o_frame_count;

  int n_pass  = 0;
  int n_total = 0;

  frame_gen_scheduler dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_num_frames  (num),
    .i_ifg_cycles  (ifg),
    .i_abort       (abort),
    .i_tx_data     (tx_data),
    .i_tx_ctrl     (tx_ctrl),
    .o_start       (o_start),
    .o_interrupt   (o_interrupt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_timeout     (o_timeout),
    .o_frame_count (o_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; observe 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle control characters on every lane: control set, no terminate.
  task automatic clr_bus();
    tx_data = {8{8'h07}};
    tx_ctrl = 8'hFF;
  endtask

  task automatic set_term(input int lane);
    tx_data = {8{8'h07}};
    tx_data[8*lane +: 8] = 8'hFD;
    tx_ctrl = 8'h01 << lane;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; num = 16'd0; ifg = 8'd0; abort = 1'b0;
    clr_bus();
    tick(); tick();
    n_total++; if (o_start !== 1'b0) $display("FAIL rst_start got=%0d exp=0", o_start); else n_pass++;
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL rst_int got=%0h exp=0", o_interrupt); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%0d exp=0", o_busy); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL rst_done got=%0d exp=0", o_done); else n_pass++;
    n_total++; if (o_timeout !== 1'b0) $display("FAIL rst_timeout got=%0d exp=0", o_timeout); else n_pass++;
    n_total++; if (o_frame_count !== 16'd0) $display("FAIL rst_count got=%0d exp=0", o_frame_count); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  // Three frames, gap 4, terminate 10 cycles after each start.
  task automatic test_multi_frame();
    logic extra;
    num = 16'd3; ifg = 8'd4; enable = 1'b1;
    tick();
    n_total++; if (o_busy !== 1'b1) $display("FAIL t1_busy got=%0d exp=1", o_busy); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      n_total++; if (o_start !== 1'b1) $display("FAIL t1_start%0d got=%0d exp=1", f, o_start); else n_pass++;
      extra = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (o_start !== 1'b0) extra = 1'b1;
      end
      n_total++; if (extra !== 1'b0) $display("FAIL t1_pulse%0d got=%0d exp=0", f, extra); else n_pass++;
      set_term(0);
      tick();
      clr_bus();
      n_total++; if (o_frame_count !== 16'(f + 1)) $display("FAIL t1_count%0d got=%0d exp=%0d", f, o_frame_count, f + 1); else n_pass++;
      if (f < 2) begin
        repeat (3) tick();
        n_total++; if (o_start !== 1'b0) $display("FAIL t1_gap%0d got=%0d exp=0", f, o_start); else n_pass++;
        tick();
      end else begin
        n_total++; if (o_done !== 1'b1) $display("FAIL t1_done got=%0d exp=1", o_done); else n_pass++;
        n_total++; if (o_busy !== 1'b1) $display("FAIL t1_busy_done got=%0d exp=1", o_busy); else n_pass++;
        enable = 1'b0;
        tick();
        n_total++; if (o_done !== 1'b0) $display("FAIL t1_done_pulse got=%0d exp=0", o_done); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL t1_busy_idle got=%0d exp=0", o_busy); else n_pass++;
      end
    end
  endtask

  // Zero gap: the start follows the terminate cycle directly.
  task automatic test_back_to_back();
    num = 16'd2; ifg = 8'd0; enable = 1'b1;
    tick();
    n_total++; if (o_start !== 1'b1) $display("FAIL t2_start0 got=%0d exp=1", o_start); else n_pass++;
    tick();
    n_total++; if (o_start !== 1'b0) $display("FAIL t2_one_cycle got=%0d exp=0", o_start); else n_pass++;
    tick(); tick();
    set_term(3);
    tick();
    clr_bus();
    n_total++; if (o_start !== 1'b1) $display("FAIL t2_b2b_start got=%0d exp=1", o_start); else n_pass++;
    n_total++; if (o_frame_count !== 16'd1) $display("FAIL t2_count1 got=%0d exp=1", o_frame_count); else n_pass++;
    tick(); tick();
    set_term(5);
    tick();
    clr_bus();
    n_total++; if (o_done !== 1'b1) $display("FAIL t2_done got=%0d exp=1", o_done); else n_pass++;
    n_total++; if (o_frame_count !== 16'd2) $display("FAIL t2_count2 got=%0d exp=2", o_frame_count); else n_pass++;
    enable = 1'b0;
    tick();
    n_total++; if (o_busy !== 1'b0) $display("FAIL t2_idle got=%0d exp=0", o_busy); else n_pass++;
  endtask

  // Watchdog expiry, timeout clearing on the next run, terminate winning on the last cycle.
  task automatic test_timeout();
    logic saw_done;
    num = 16'd1; ifg = 8'd0; enable = 1'b1;
    tick();
    saw_done = 1'b0;
    for (int c = 0; c < 2048; c++) begin
      tick();
      if (o_done !== 1'b0) saw_done = 1'b1;
    end
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t3_int_early got=%0h exp=0", o_interrupt); else n_pass++;
    n_total++; if (o_timeout !== 1'b0) $display("FAIL t3_to_early got=%0d exp=0", o_timeout); else n_pass++;
    tick();
    if (o_done !== 1'b0) saw_done = 1'b1;
    n_total++; if (o_interrupt !== 8'h02) $display("FAIL t3_int got=%0h exp=2", o_interrupt); else n_pass++;
    n_total++; if (o_timeout !== 1'b1) $display("FAIL t3_timeout got=%0d exp=1", o_timeout); else n_pass++;
    enable = 1'b0;
    tick();
    if (o_done !== 1'b0) saw_done = 1'b1;
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t3_int_pulse got=%0h exp=0", o_interrupt); else n_pass++;
    n_total++; if (o_timeout !== 1'b1) $display("FAIL t3_sticky got=%0d exp=1", o_timeout); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL t3_idle got=%0d exp=0", o_busy); else n_pass++;
    n_total++; if (saw_done !== 1'b0) $display("FAIL t3_no_done got=%0d exp=0", saw_done); else n_pass++;
    enable = 1'b1;
    tick();
    n_total++; if (o_timeout !== 1'b0) $display("FAIL t3_to_clear got=%0d exp=0", o_timeout); else n_pass++;
    repeat (2048) tick();
    set_term(1);
    tick();
    clr_bus();
    n_total++; if (o_done !== 1'b1) $display("FAIL t3_term_wins got=%0d exp=1", o_done); else n_pass++;
    n_total++; if (o_timeout !== 1'b0) $display("FAIL t3_term_to got=%0d exp=0", o_timeout); else n_pass++;
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t3_term_int got=%0h exp=0", o_interrupt); else n_pass++;
    enable = 1'b0;
    tick();
  endtask

  // Abort during frame 2, abort ignored in IDLE, abort coinciding with terminate.
  task automatic test_abort();
    num = 16'd3; ifg = 8'd2; enable = 1'b1;
    tick();
    repeat (5) tick();
    set_term(2);
    tick();
    clr_bus();
    tick(); tick();
    n_total++; if (o_start !== 1'b1) $display("FAIL t4_start2 got=%0d exp=1", o_start); else n_pass++;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    n_total++; if (o_interrupt !== 8'h02) $display("FAIL t4_int got=%0h exp=2", o_interrupt); else n_pass++;
    n_total++; if (o_frame_count !== 16'd1) $display("FAIL t4_count got=%0d exp=1", o_frame_count); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL t4_no_done got=%0d exp=0", o_done); else n_pass++;
    abort = 1'b0; enable = 1'b0;
    tick();
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t4_int_clear got=%0h exp=0", o_interrupt); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL t4_idle got=%0d exp=0", o_busy); else n_pass++;
    abort = 1'b1;
    tick();
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t4_idle_abort got=%0h exp=0", o_interrupt); else n_pass++;
    abort = 1'b0;
    num = 16'd3; ifg = 8'd0; enable = 1'b1;
    tick();
    n_total++; if (o_frame_count !== 16'd0) $display("FAIL t4_count_clear got=%0d exp=0", o_frame_count); else n_pass++;
    tick(); tick();
    set_term(4);
    tick();
    clr_bus();
    tick(); tick();
    set_term(6); abort = 1'b1;
    tick();
    clr_bus(); abort = 1'b0; enable = 1'b0;
    n_total++; if (o_frame_count !== 16'd2) $display("FAIL t4_abort_term_count got=%0d exp=2", o_frame_count); else n_pass++;
    n_total++; if (o_interrupt !== 8'h02) $display("FAIL t4_abort_term_int got=%0h exp=2", o_interrupt); else n_pass++;
    tick();
  endtask

  // Continuous mode: dropping enable lets the current frame finish.
  task automatic test_continuous_stop();
    num = 16'd0; ifg = 8'd1; enable = 1'b1;
    tick();
    tick(); tick();
    set_term(0);
    tick();
    clr_bus();
    n_total++; if (o_start !== 1'b0) $display("FAIL t5_gap got=%0d exp=0", o_start); else n_pass++;
    tick();
    n_total++; if (o_start !== 1'b1) $display("FAIL t5_start got=%0d exp=1", o_start); else n_pass++;
    tick(); tick();
    enable = 1'b0;
    tick();
    n_total++; if (o_done !== 1'b0) $display("FAIL t5_early_done got=%0d exp=0", o_done); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL t5_still_busy got=%0d exp=1", o_busy); else n_pass++;
    tick();
    set_term(7);
    tick();
    clr_bus();
    n_total++; if (o_done !== 1'b1) $display("FAIL t5_done got=%0d exp=1", o_done); else n_pass++;
    n_total++; if (o_frame_count !== 16'd2) $display("FAIL t5_count got=%0d exp=2", o_frame_count); else n_pass++;
    tick();
    n_total++; if (o_busy !== 1'b0) $display("FAIL t5_idle got=%0d exp=0", o_busy); else n_pass++;
  endtask

  // Edge lanes detected, non-terminate byte ignored, reset mid-frame is silent.
  task automatic test_lanes_and_reset();
    num = 16'd0; ifg = 8'd0; enable = 1'b1;
    tick();
    tick(); tick();
    set_term(0);
    tick();
    clr_bus();
    n_total++; if (o_frame_count !== 16'd1) $display("FAIL t6_lane0 got=%0d exp=1", o_frame_count); else n_pass++;
    tick();
    set_term(7);
    tick();
    clr_bus();
    n_total++; if (o_frame_count !== 16'd2) $display("FAIL t6_lane7 got=%0d exp=2", o_frame_count); else n_pass++;
    tick();
    tx_data = {8{8'h07}};
    tx_data[31:24] = 8'hFD;
    tx_ctrl = 8'hF7;
    tick();
    clr_bus();
    n_total++; if (o_frame_count !== 16'd2) $display("FAIL t6_no_ctrl got=%0d exp=2", o_frame_count); else n_pass++;
    n_total++; if (o_start !== 1'b0) $display("FAIL t6_no_ctrl_start got=%0d exp=0", o_start); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if (o_busy !== 1'b0) $display("FAIL t6_rst_busy got=%0d exp=0", o_busy); else n_pass++;
    n_total++; if (o_frame_count !== 16'd0) $display("FAIL t6_rst_count got=%0d exp=0", o_frame_count); else n_pass++;
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t6_rst_int got=%0h exp=0", o_interrupt); else n_pass++;
    n_total++; if (o_start !== 1'b0) $display("FAIL t6_rst_start got=%0d exp=0", o_start); else n_pass++;
    rst_n = 1'b1; enable = 1'b0;
    tick();
    n_total++; if (o_interrupt !== 8'h00) $display("FAIL t6_post_int got=%0h exp=0", o_interrupt); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL t6_post_busy got=%0d exp=0", o_busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_multi_frame();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_continuous_stop();
    test_lanes_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
